// File: rtl/ysyx_22040759_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core.
// Inserts a bubble on load-use hazards and freezes the front end and EX
// while a multi-cycle mul/div runs. It also performs the one-cycle
// front-end flush after a taken branch or jump, and counts stall cycles.
module ysyx_22040759_hazard_ctrl #(
  parameter int MD_TIMEOUT = 70,
  parameter int CNT_W      = 7,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ds_valid,
  input  logic [4:0]        ds_rs1,
  input  logic [4:0]        ds_rs2,
  input  logic              es_valid,
  input  logic              es_mem_ren,
  input  logic              es_reg_wen,
  input  logic [4:0]        es_rd,
  input  logic              es_md_start,
  input  logic              md_done,
  input  logic              br_taken,
  output logic              IF_ID_write,
  output logic              en_control,
  output logic              pc_hold,
  output logic              es_hold,
  output logic              flush,
  output logic              md_timeout,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MDWAIT = 2'd1,
    FLUSH  = 2'd2
  } st_e;

  // The counter holds the number of held cycles after the start cycle.
  // The release happens once the hold has lasted MD_TIMEOUT cycles in total.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  st_e               st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              mdto_q, mdto_d;
  logic              luh;
  logic              ifid_c, enc_c, pch_c, esh_c, flush_c;

  assign luh = ds_valid & es_valid & es_mem_ren & es_reg_wen & (es_rd != 5'd0) &
               ((es_rd == ds_rs1) | (es_rd == ds_rs2));

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next state, wait counter and same-cycle stall controls.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    mdto_d  = 1'b0;
    ifid_c  = 1'b0;
    enc_c   = 1'b0;
    pch_c   = 1'b0;
    esh_c   = 1'b0;
    flush_c = 1'b0;
    case (st_q)
      RUN: begin
        if (br_taken) begin
          flush_c = 1'b1;
          enc_c   = 1'b1;
          st_d    = FLUSH;
        end else if (es_md_start) begin
          pch_c  = 1'b1;
          ifid_c = 1'b1;
          esh_c  = 1'b1;
          cnt_d  = '0;
          if (!md_done) st_d = MDWAIT;
        end else if (luh) begin
          pch_c  = 1'b1;
          ifid_c = 1'b1;
          enc_c  = 1'b1;
        end
      end
      MDWAIT: begin
        pch_c  = 1'b1;
        ifid_c = 1'b1;
        esh_c  = 1'b1;
        cnt_d  = cnt_inc;
        if (md_done) begin
          st_d = RUN;
        end else if (cnt_inc == CNT_LAST) begin
          st_d   = RUN;
          mdto_d = 1'b1;
        end
      end
      FLUSH: begin
        enc_c = 1'b1;
        st_d  = RUN;
        if (br_taken) begin
          flush_c = 1'b1;
          st_d    = FLUSH;
        end
      end
      default: st_d = RUN;
    endcase

    stall_d = stall_q;
    if (pch_c && (stall_q != {PERF_W{1'b1}})) stall_d = stall_q + PERF_W'(1);
  end

  // State, wait counter, timeout pulse and performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      mdto_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      mdto_q  <= mdto_d;
    end
  end

  assign IF_ID_write = ifid_c  & ~rst;
  assign en_control  = enc_c   & ~rst;
  assign pc_hold     = pch_c   & ~rst;
  assign es_hold     = esh_c   & ~rst;
  assign flush       = flush_c & ~rst;
  assign md_timeout  = mdto_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_ysyx_22040759_hazard_ctrl.sv
// Scoreboard bench for the hazard sequencer: each driven cycle pushes its
// expected outputs, and the negedge checker pops and compares them.
module tb_ysyx_22040759_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic       dsValid;
      logic [4:0] dsRs1;
      logic [4:0] dsRs2;
      logic       esValid;
      logic       esMemRen;
      logic       esRegWen;
      logic [4:0] esRd;
      logic       esMdStart;
      logic       mdDone;
      logic       brTaken;
   } stim_t;

   // Flag order: {IF_ID_write, en_control, pc_hold, es_hold, flush, md_timeout}
   localparam logic [5:0] NONE    = 6'b000000;
   localparam logic [5:0] HOLD_LU = 6'b111000;
   localparam logic [5:0] HOLD_MD = 6'b101100;
   localparam logic [5:0] BRANCH  = 6'b010010;
   localparam logic [5:0] SQUASH  = 6'b010000;
   localparam logic [5:0] TIMEOUT = 6'b000001;

   logic        clk;
   logic        rst;
   logic        dsValid, esValid, esMemRen, esRegWen, esMdStart, mdDone, brTaken;
   logic [4:0]  dsRs1, dsRs2, esRd;
   logic        ifIdWrite, enControl, pcHold, esHold, flushO, mdTimeout;
   logic [31:0] stallCnt;

   logic [5:0]  sbFlags[$];
   logic [31:0] sbStall[$];
   string       sbTag[$];
   logic [31:0] benchStall;
   int          nCompared;
   int          nMismatched;

   ysyx_22040759_hazard_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .ds_valid   (dsValid),
      .ds_rs1     (dsRs1),
      .ds_rs2     (dsRs2),
      .es_valid   (esValid),
      .es_mem_ren (esMemRen),
      .es_reg_wen (esRegWen),
      .es_rd      (esRd),
      .es_md_start(esMdStart),
      .md_done    (mdDone),
      .br_taken   (brTaken),
      .IF_ID_write(ifIdWrite),
      .en_control (enControl),
      .pc_hold    (pcHold),
      .es_hold    (esHold),
      .flush      (flushO),
      .md_timeout (mdTimeout),
      .stall_cnt  (stallCnt)
   );

   // Free-running core clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t loadUse(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      stim_t s;
      s = '0;
      s.dsValid  = 1'b1;
      s.dsRs1    = rs1;
      s.dsRs2    = rs2;
      s.esValid  = 1'b1;
      s.esMemRen = 1'b1;
      s.esRegWen = 1'b1;
      s.esRd     = rd;
      return s;
   endfunction

   // Drives one cycle of inputs just after the clock edge and queues the expected outputs.
   task automatic applyStimulus(input string tag, input stim_t s, input logic [5:0] expFlags);
      @(posedge clk);
      #1;
      rst       = s.rst;
      dsValid   = s.dsValid;
      dsRs1     = s.dsRs1;
      dsRs2     = s.dsRs2;
      esValid   = s.esValid;
      esMemRen  = s.esMemRen;
      esRegWen  = s.esRegWen;
      esRd      = s.esRd;
      esMdStart = s.esMdStart;
      mdDone    = s.mdDone;
      brTaken   = s.brTaken;
      if (s.rst) benchStall = 32'd0;
      sbFlags.push_back(expFlags);
      sbStall.push_back(benchStall);
      sbTag.push_back(tag);
      if (expFlags[3] && benchStall != 32'hFFFF_FFFF) benchStall = benchStall + 32'd1;
   endtask

   // Compares the oldest queued expectation against the DUT on the falling edge.
   always @(negedge clk) begin
      logic [5:0]  f;
      logic [31:0] sv;
      string       t;
      if (sbFlags.size() != 0) begin
         f  = sbFlags.pop_front();
         sv = sbStall.pop_front();
         t  = sbTag.pop_front();
         checkOutput({t, " flags"},
                     {26'd0, ifIdWrite, enControl, pcHold, esHold, flushO, mdTimeout},
                     {26'd0, f});
         checkOutput({t, " stall_cnt"}, stallCnt, sv);
      end
   end

   // Directed scenarios for load-use, mul/div wait, timeout, branch flush and reset.
   initial begin
      stim_t s;
      nCompared   = 0;
      nMismatched = 0;
      benchStall  = 32'd0;
      rst = 1'b1;
      dsValid = 1'b0; esValid = 1'b0; esMemRen = 1'b0; esRegWen = 1'b0;
      esMdStart = 1'b0; mdDone = 1'b0; brTaken = 1'b0;
      dsRs1 = 5'd0; dsRs2 = 5'd0; esRd = 5'd0;

      s = idleStim();
      s.rst = 1'b1;
      applyStimulus("reset0", s, NONE);
      s = loadUse(5'd5, 5'd5, 5'd1);
      s.rst = 1'b1;
      applyStimulus("reset_with_luh", s, NONE);
      applyStimulus("idle", idleStim(), NONE);

      applyStimulus("luh_rs1", loadUse(5'd5, 5'd5, 5'd1), HOLD_LU);
      applyStimulus("luh_after", idleStim(), NONE);
      applyStimulus("luh_rs2", loadUse(5'd7, 5'd3, 5'd7), HOLD_LU);
      applyStimulus("luh_miss", loadUse(5'd5, 5'd4, 5'd21), NONE);
      applyStimulus("load_x0", loadUse(5'd0, 5'd0, 5'd0), NONE);
      s = loadUse(5'd9, 5'd9, 5'd0);
      s.esMemRen = 1'b0;
      applyStimulus("not_load", s, NONE);
      s = loadUse(5'd9, 5'd9, 5'd0);
      s.dsValid = 1'b0;
      applyStimulus("ds_invalid", s, NONE);
      applyStimulus("luh_hi_bit", loadUse(5'd17, 5'd1, 5'd1), NONE);

      s = idleStim();
      s.esMdStart = 1'b1;
      applyStimulus("md_start", s, HOLD_MD);
      for (int i = 1; i <= 33; i++) begin
         s = idleStim();
         if (i == 5) s.brTaken = 1'b1;
         if (i == 6) s = loadUse(5'd5, 5'd5, 5'd5);
         if (i == 33) s.mdDone = 1'b1;
         applyStimulus($sformatf("md_wait%0d", i), s, HOLD_MD);
      end
      applyStimulus("md_release", idleStim(), NONE);
      applyStimulus("md_no_to", idleStim(), NONE);

      s = idleStim();
      s.esMdStart = 1'b1;
      s.mdDone    = 1'b1;
      applyStimulus("md_instant", s, HOLD_MD);
      applyStimulus("md_instant_after", idleStim(), NONE);

      s = idleStim();
      s.esMdStart = 1'b1;
      applyStimulus("to_start", s, HOLD_MD);
      for (int i = 1; i <= 69; i++) begin
         applyStimulus($sformatf("to_wait%0d", i), idleStim(), HOLD_MD);
      end
      applyStimulus("to_pulse", idleStim(), TIMEOUT);
      s = idleStim();
      s.mdDone = 1'b1;
      applyStimulus("to_late_done", s, NONE);

      s = loadUse(5'd5, 5'd5, 5'd1);
      s.brTaken = 1'b1;
      applyStimulus("br_luh", s, BRANCH);
      applyStimulus("flush_luh", loadUse(5'd5, 5'd5, 5'd1), SQUASH);
      applyStimulus("flush_done", idleStim(), NONE);
      s = idleStim();
      s.brTaken = 1'b1;
      applyStimulus("br_a", s, BRANCH);
      applyStimulus("br_in_flush", s, BRANCH);
      applyStimulus("flush_b", idleStim(), SQUASH);
      applyStimulus("flush_b_done", idleStim(), NONE);

      s = idleStim();
      s.esMdStart = 1'b1;
      applyStimulus("rmd_start", s, HOLD_MD);
      for (int i = 1; i <= 9; i++) begin
         applyStimulus($sformatf("rmd_wait%0d", i), idleStim(), HOLD_MD);
      end
      s = idleStim();
      s.rst = 1'b1;
      applyStimulus("rmd_reset", s, NONE);
      s = idleStim();
      s.mdDone = 1'b1;
      applyStimulus("rmd_late_done", s, NONE);
      applyStimulus("rmd_idle", idleStim(), NONE);
      applyStimulus("rmd_luh", loadUse(5'd31, 5'd2, 5'd31), HOLD_LU);
      applyStimulus("rmd_end", idleStim(), NONE);

      for (int k = 0; k < 20 && sbFlags.size() != 0; k++) @(negedge clk);
      #1;
      checkOutput("drain", sbFlags.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
